// File: rtl/flop_r.sv
// N-bit D register with asynchronous active-low clear.
// State element for the PC and other datapath holders; q is always registered.
module flop_r #(
   parameter int N = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);

   // Clear wins over a coincident clock edge because the reset branch is tested first.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= '0;
      end else begin
         q <= d;
      end
   end

endmodule

// File: tb/tb_flop_r.sv
// Bench for flop_r at widths 64, 32 and 1, sharing clock, reset and data.
// Expected q is tracked by a behavioural model: the last clocked d while out of reset, else zero.
module tb_flop_r;

   logic        clk;
   logic        reset;
   logic [63:0] d;
   logic [63:0] q64;
   logic [31:0] d32;
   logic [31:0] q32;
   logic [0:0]  d1;
   logic [0:0]  q1;

   logic [63:0] mq;
   int          tests;
   int          failed;

   assign d32 = d[31:0];
   assign d1  = d[0:0];

   flop_r #(.N(64)) u_dut64 (.clk(clk), .reset(reset), .d(d),   .q(q64));
   flop_r #(.N(32)) u_dut32 (.clk(clk), .reset(reset), .d(d32), .q(q32));
   flop_r #(.N(1))  u_dut1  (.clk(clk), .reset(reset), .d(d1),  .q(q1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag);
      tests++;
      assert (q64 === mq) else begin
         failed++;
         $error("FAIL %s n64 observed=%h expected=%h", tag, q64, mq);
      end
      tests++;
      assert (q32 === mq[31:0]) else begin
         failed++;
         $error("FAIL %s n32 observed=%h expected=%h", tag, q32, mq[31:0]);
      end
      tests++;
      assert (q1 === mq[0:0]) else begin
         failed++;
         $error("FAIL %s n1 observed=%b expected=%b", tag, q1, mq[0]);
      end
   endtask

   // Rising edge: the model takes d when out of reset, zero otherwise.
   task automatic tick();
      @(posedge clk);
      mq = reset ? d : 64'h0;
      #1;
   endtask

   task automatic drive_mid(input logic [63:0] val);
      @(negedge clk);
      d = val;
   endtask

   task automatic assert_reset_now();
      reset = 1'b0;
      mq    = 64'h0;
      #1;
   endtask

   initial begin
      logic [63:0] v;
      tests  = 0;
      failed = 0;
      reset  = 1'b1;
      d      = 64'hFFFF_FFFF_FFFF_FFFF;
      mq     = 64'h0;

      #2;
      assert_reset_now();
      check("power_on_clear");

      for (int i = 0; i < 5; i++) begin
         drive_mid(64'hFFFF_FFFF_FFFF_FFFF - 64'(i));
         tick();
         check("reset_dominance");
      end

      drive_mid(64'hFFFF_FFFF_FFFF_FFFA);
      reset = 1'b1;
      #1;
      check("release_no_change");
      tick();
      check("capture_after_release");

      for (int i = 0; i < 4; i++) begin
         drive_mid(64'hFFFF_FFFF_FFFF_FFF9 - 64'(i));
         tick();
         check("streaming");
      end

      drive_mid(64'h1234_5678_9ABC_DEF0);
      tick();
      check("load_before_clear");
      @(negedge clk);
      #2;
      assert_reset_now();
      check("async_clear_mid_cycle");
      tick();
      check("reset_held_across_edge");
      @(negedge clk);
      reset = 1'b1;

      drive_mid(64'hA5A5_A5A5_A5A5_A5A5);
      tick();
      check("hold_load");
      for (int i = 0; i < 4; i++) begin
         #2;
         d = {$urandom, $urandom};
         #0;
         check("hold_between_edges");
      end
      tick();
      check("hold_then_capture");

      drive_mid(64'h0);
      tick();
      check("corner_zero");
      drive_mid(64'hFFFF_FFFF_FFFF_FFFF);
      tick();
      check("corner_ones");
      drive_mid(64'h8000_0000_0000_0001);
      tick();
      check("corner_msb_lsb");

      for (int i = 0; i < 200; i++) begin
         v = {$urandom, $urandom};
         drive_mid(v);
         if ($urandom_range(0, 7) == 0) begin
            if (reset) begin
               assert_reset_now();
               check("random_async_clear");
            end else begin
               reset = 1'b1;
               #1;
               check("random_release");
            end
         end
         tick();
         check("random_stream");
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
